audio_rx_stage: RTL and testbench

//  Downstream of i2s_ctrl. Once per LRCLK frame, captures the stereo ADC samples (D_L_O/D_R_O).

---
 rtl/audio_pkg.sv | 35 +++
 rtl/sync_fifo.sv | 57 +++++
 rtl/audio_rx_stage.sv | 144 ++++++++++++++
 tb/tb_audio_rx_stage.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared widths, the stereo frame type and the Q4.12 shift/saturate helper
// for the audio receive path.
package audio_pkg;

   localparam int SAMPLE_W  = 24;
   localparam int GAIN_W    = 16;
   localparam int GAIN_FRAC = 12;
   localparam int PROD_W    = SAMPLE_W + GAIN_W + 1;

   typedef struct packed {
      logic signed [SAMPLE_W-1:0] l;
      logic signed [SAMPLE_W-1:0] r;
   } stereo_t;

   localparam logic signed [PROD_W-1:0] SAT_MAX =
      {{(PROD_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
   localparam logic signed [PROD_W-1:0] SAT_MIN =
      {{(PROD_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

   // Arithmetic shift floors toward minus infinity, so -1 * 0.5 stays -1.
   function automatic logic signed [SAMPLE_W-1:0] sat_shift(
      input logic signed [PROD_W-1:0] prod
   );
      logic signed [PROD_W-1:0] sh;
      sh = prod >>> GAIN_FRAC;
      if (sh > SAT_MAX) begin
         return SAT_MAX[SAMPLE_W-1:0];
      end else if (sh < SAT_MIN) begin
         return SAT_MIN[SAMPLE_W-1:0];
      end else begin
         return sh[SAMPLE_W-1:0];
      end
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO; the head is presented directly
// from storage and reads as zero while empty.
module sync_fifo #(
   parameter  int WIDTH = 48,
   parameter  int DEPTH = 8,
   localparam int AW    = $clog2(DEPTH),
   localparam int LW    = AW + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] din_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] dout_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [LW-1:0]    level_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [LW-1:0]    level_q;
   logic             do_push;
   logic             do_pop;

   assign full_o  = (level_q == LW'(DEPTH));
   assign empty_o = (level_q == '0);
   assign level_o = level_q;
   assign do_pop  = pop_i & ~empty_o;
   // A full FIFO still accepts a write when the head leaves in the same cycle.
   assign do_push = push_i & (~full_o | do_pop);
   assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   level_q <= level_q + LW'(1);
            2'b01:   level_q <= level_q - LW'(1);
            default: level_q <= level_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && do_push) begin
         mem_q[wr_ptr_q] <= din_i;
      end
   end

endmodule

// File: rtl/audio_rx_stage.sv
// Captures one stereo frame per LRCLK rise, applies gain/mute through a
// three-stage pipeline and queues the results for a valid/ready consumer.
module audio_rx_stage
   import audio_pkg::*;
#(
   parameter  int FIFO_DEPTH = 8,
   localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en_i,
   input  logic                lrclk_i,
   input  logic [SAMPLE_W-1:0] d_l_i,
   input  logic [SAMPLE_W-1:0] d_r_i,
   input  logic [GAIN_W-1:0]   gain_l_i,
   input  logic [GAIN_W-1:0]   gain_r_i,
   input  logic                mute_i,
   output logic                m_valid_o,
   input  logic                m_ready_i,
   output logic [SAMPLE_W-1:0] m_l_o,
   output logic [SAMPLE_W-1:0] m_r_o,
   output logic [LVL_W-1:0]    level_o,
   output logic                ovf_o,
   input  logic                clr_ovf_i,
   output logic [15:0]         drop_cnt_o
);

   logic                       lrclk_q;
   logic                       frame_stb;
   logic                       s0_vld_q;
   logic signed [SAMPLE_W-1:0] s0_l_q, s0_r_q;
   logic [GAIN_W-1:0]          s0_gl_q, s0_gr_q;
   logic                       s0_mute_q;
   logic                       s1_vld_q;
   logic                       s1_mute_q;
   logic signed [PROD_W-1:0]   s1_pl_q, s1_pr_q, s1_pl_d, s1_pr_d;
   stereo_t                    s2_frame;
   logic                       s2_vld;
   logic [2*SAMPLE_W-1:0]      fifo_din, fifo_dout;
   logic                       fifo_full, fifo_empty;
   logic                       push, pop, drop;
   logic                       ovf_q, ovf_d;
   logic [15:0]                drop_cnt_q, drop_cnt_d;

   assign frame_stb = lrclk_i & ~lrclk_q & en_i;

   // Sign-extended sample times zero-extended gain; the exact product fits PROD_W bits.
   always_comb begin
      s1_pl_d = $signed({{(GAIN_W+1){s0_l_q[SAMPLE_W-1]}}, s0_l_q}
                        * {{SAMPLE_W{1'b0}}, 1'b0, s0_gl_q});
      s1_pr_d = $signed({{(GAIN_W+1){s0_r_q[SAMPLE_W-1]}}, s0_r_q}
                        * {{SAMPLE_W{1'b0}}, 1'b0, s0_gr_q});
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lrclk_q   <= 1'b0;
         s0_vld_q  <= 1'b0;
         s0_l_q    <= '0;
         s0_r_q    <= '0;
         s0_gl_q   <= '0;
         s0_gr_q   <= '0;
         s0_mute_q <= 1'b0;
         s1_vld_q  <= 1'b0;
         s1_mute_q <= 1'b0;
         s1_pl_q   <= '0;
         s1_pr_q   <= '0;
      end else begin
         lrclk_q  <= lrclk_i;
         s0_vld_q <= frame_stb;
         if (frame_stb) begin
            s0_l_q    <= d_l_i;
            s0_r_q    <= d_r_i;
            s0_gl_q   <= gain_l_i;
            s0_gr_q   <= gain_r_i;
            s0_mute_q <= mute_i;
         end
         s1_vld_q  <= s0_vld_q;
         s1_mute_q <= s0_mute_q;
         s1_pl_q   <= s1_pl_d;
         s1_pr_q   <= s1_pr_d;
      end
   end

   // Final stage is combinational from S1 and writes straight into the FIFO.
   always_comb begin
      s2_vld     = s1_vld_q;
      s2_frame.l = s1_mute_q ? '0 : sat_shift(s1_pl_q);
      s2_frame.r = s1_mute_q ? '0 : sat_shift(s1_pr_q);
   end

   // Stream: a beat transfers on each clock edge where m_valid_o and m_ready_i
   // are both high; m_valid_o comes from FIFO state only and the head data is
   // stable until its beat transfers.
   assign pop  = m_valid_o & m_ready_i;
   assign push = s2_vld & (~fifo_full | pop);
   assign drop = s2_vld & fifo_full & ~pop;
   assign fifo_din = s2_frame;

   sync_fifo #(
      .WIDTH (2*SAMPLE_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .din_i   (fifo_din),
      .pop_i   (pop),
      .dout_o  (fifo_dout),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (level_o)
   );

   assign m_valid_o = ~fifo_empty;
   assign m_l_o     = fifo_dout[2*SAMPLE_W-1:SAMPLE_W];
   assign m_r_o     = fifo_dout[SAMPLE_W-1:0];

   always_comb begin
      ovf_d      = ovf_q;
      drop_cnt_d = drop_cnt_q;
      if (clr_ovf_i) begin
         ovf_d      = 1'b0;
         drop_cnt_d = '0;
      end else if (drop) begin
         ovf_d = 1'b1;
         if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ovf_q      <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         ovf_q      <= ovf_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign ovf_o      = ovf_q;
   assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_audio_rx_stage.sv
// Directed bench for audio_rx_stage: latency, gain/saturation, mute,
// overflow accounting, push-while-full and reset discard.
module tb_audio_rx_stage;

   logic        clk;
   logic        rst_n;
   logic        en_i;
   logic        lrclk_i;
   logic [23:0] d_l_i, d_r_i;
   logic [15:0] gain_l_i, gain_r_i;
   logic        mute_i;
   logic        m_valid_o;
   logic        m_ready_i;
   logic [23:0] m_l_o, m_r_o;
   logic [3:0]  level_o;
   logic        ovf_o;
   logic        clr_ovf_i;
   logic [15:0] drop_cnt_o;

   int errors = 0;
   int checks = 0;
   logic [47:0] exp_q[$];

   audio_rx_stage dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en_i       (en_i),
      .lrclk_i    (lrclk_i),
      .d_l_i      (d_l_i),
      .d_r_i      (d_r_i),
      .gain_l_i   (gain_l_i),
      .gain_r_i   (gain_r_i),
      .mute_i     (mute_i),
      .m_valid_o  (m_valid_o),
      .m_ready_i  (m_ready_i),
      .m_l_o      (m_l_o),
      .m_r_o      (m_r_o),
      .level_o    (level_o),
      .ovf_o      (ovf_o),
      .clr_ovf_i  (clr_ovf_i),
      .drop_cnt_o (drop_cnt_o)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [23:0] l, input logic [23:0] r);
      d_l_i   = l;
      d_r_i   = r;
      lrclk_i = 1'b1;
      tick();
      lrclk_i = 1'b0;
      tick();
   endtask

   task automatic drain_check(input string tag);
      logic [47:0] e;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check({tag, "_valid"}, {47'd0, m_valid_o}, 48'd1);
         check({tag, "_data"}, {m_l_o, m_r_o}, e);
         m_ready_i = 1'b1;
         tick();
         m_ready_i = 1'b0;
      end
      check({tag, "_empty"}, {47'd0, m_valid_o}, 48'd0);
      check({tag, "_level0"}, {44'd0, level_o}, 48'd0);
   endtask

   initial begin
      rst_n = 1'b0; en_i = 1'b1; lrclk_i = 1'b0;
      d_l_i = '0; d_r_i = '0;
      gain_l_i = 16'h1000; gain_r_i = 16'h1000;
      mute_i = 1'b0; m_ready_i = 1'b0; clr_ovf_i = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      tick();

      check("rst_valid", {47'd0, m_valid_o}, 48'd0);
      check("rst_level", {44'd0, level_o}, 48'd0);
      check("rst_ovf",   {47'd0, ovf_o}, 48'd0);
      check("rst_cnt",   {32'd0, drop_cnt_o}, 48'd0);
      check("rst_data",  {m_l_o, m_r_o}, 48'd0);

      // 1: unity gain, latency N+3
      d_l_i = 24'h123456; d_r_i = 24'hFEDCBA; lrclk_i = 1'b1;
      tick();
      check("t1_n1_valid", {47'd0, m_valid_o}, 48'd0);
      lrclk_i = 1'b0;
      tick();
      check("t1_n2_valid", {47'd0, m_valid_o}, 48'd0);
      tick();
      check("t1_n3_valid", {47'd0, m_valid_o}, 48'd1);
      check("t1_data", {m_l_o, m_r_o}, {24'h123456, 24'hFEDCBA});
      check("t1_level", {44'd0, level_o}, 48'd1);
      m_ready_i = 1'b1; tick(); m_ready_i = 1'b0;
      check("t1_popped", {47'd0, m_valid_o}, 48'd0);

      // 2: x2 saturation both directions
      gain_l_i = 16'h2000; gain_r_i = 16'h2000;
      send_frame(24'h500000, 24'h9FFFFF);
      tick();
      exp_q.push_back({24'h7FFFFF, 24'h800000});
      drain_check("t2");

      // 3: x0.5 floor, mute, mid-frame gain/mute changes ignored
      gain_l_i = 16'h0800; gain_r_i = 16'h0800;
      send_frame(24'hFFFFFF, 24'h000100);
      tick();
      exp_q.push_back({24'hFFFFFF, 24'h000080});
      drain_check("t3_half");
      mute_i = 1'b1;
      d_l_i = 24'h123456; d_r_i = 24'h123456; lrclk_i = 1'b1;
      tick();
      mute_i = 1'b0; lrclk_i = 1'b0;
      tick(); tick();
      exp_q.push_back(48'd0);
      drain_check("t3_mute");
      gain_l_i = 16'h1000; gain_r_i = 16'h1000;
      d_l_i = 24'h000010; d_r_i = 24'hFFFFF0; lrclk_i = 1'b1;
      tick();
      gain_l_i = 16'h4000; gain_r_i = 16'h0000; lrclk_i = 1'b0;
      tick(); tick();
      exp_q.push_back({24'h000010, 24'hFFFFF0});
      drain_check("t3_gainhold");
      gain_l_i = 16'h1000; gain_r_i = 16'h1000;

      // en_i=0 ignores frames
      en_i = 1'b0;
      send_frame(24'h111111, 24'h222222);
      tick(); tick();
      check("en_off_level", {44'd0, level_o}, 48'd0);
      en_i = 1'b1;

      // 4: overflow with ten frames into eight slots
      for (int i = 0; i < 10; i++) begin
         send_frame(24'h100000 + 24'(i), 24'hF00000 + 24'(i));
         if (i < 8) exp_q.push_back({24'h100000 + 24'(i), 24'hF00000 + 24'(i)});
      end
      tick(); tick();
      check("t4_level", {44'd0, level_o}, 48'd8);
      check("t4_ovf", {47'd0, ovf_o}, 48'd1);
      check("t4_cnt", {32'd0, drop_cnt_o}, 48'd2);
      drain_check("t4_drain");

      // 5: push while full with a same-cycle pop, then clear against a drop
      clr_ovf_i = 1'b1; tick(); clr_ovf_i = 1'b0;
      check("t5_clr_ovf", {47'd0, ovf_o}, 48'd0);
      check("t5_clr_cnt", {32'd0, drop_cnt_o}, 48'd0);
      for (int i = 0; i < 8; i++) begin
         send_frame(24'h200000 + 24'(i), 24'h300000 + 24'(i));
         exp_q.push_back({24'h200000 + 24'(i), 24'h300000 + 24'(i)});
      end
      tick(); tick();
      check("t5_full", {44'd0, level_o}, 48'd8);
      send_frame(24'h0ABCDE, 24'h0EDCBA);
      m_ready_i = 1'b1; tick(); m_ready_i = 1'b0;
      void'(exp_q.pop_front());
      exp_q.push_back({24'h0ABCDE, 24'h0EDCBA});
      check("t5_pp_level", {44'd0, level_o}, 48'd8);
      check("t5_pp_ovf", {47'd0, ovf_o}, 48'd0);
      check("t5_pp_cnt", {32'd0, drop_cnt_o}, 48'd0);
      send_frame(24'h555555, 24'h666666);
      clr_ovf_i = 1'b1; tick(); clr_ovf_i = 1'b0;
      check("t5_clrdrop_ovf", {47'd0, ovf_o}, 48'd0);
      check("t5_clrdrop_cnt", {32'd0, drop_cnt_o}, 48'd0);
      check("t5_clrdrop_level", {44'd0, level_o}, 48'd8);
      send_frame(24'h777777, 24'h888888);
      tick();
      check("t5_drop_ovf", {47'd0, ovf_o}, 48'd1);
      check("t5_drop_cnt", {32'd0, drop_cnt_o}, 48'd1);
      drain_check("t5_drain");

      // 6: reset with a frame at S1 and three queued
      for (int i = 0; i < 3; i++) send_frame(24'h400000 + 24'(i), 24'h0);
      tick(); tick();
      check("t6_pre_level", {44'd0, level_o}, 48'd3);
      d_l_i = 24'h0DEAD0; d_r_i = 24'h0BEEF0; lrclk_i = 1'b1;
      tick();
      lrclk_i = 1'b0;
      tick();
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      check("t6_level", {44'd0, level_o}, 48'd0);
      check("t6_valid", {47'd0, m_valid_o}, 48'd0);
      check("t6_ovf", {47'd0, ovf_o}, 48'd0);
      check("t6_cnt", {32'd0, drop_cnt_o}, 48'd0);
      tick(); tick(); tick();
      check("t6_no_stale", {47'd0, m_valid_o}, 48'd0);
      check("t6_no_stale_lvl", {44'd0, level_o}, 48'd0);
      check("t6_data_zero", {m_l_o, m_r_o}, 48'd0);

      // final report
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
